spi_slave_rx: RTL and testbench

SPI slave receiver. It is the target-side counterpart of the team's SPI command master, used in loopback test fixtures and on daughter-board FPGAs that receive commands from that master. It oversamples SPI_CLK, SPI_SS and MOSI on the local system clock, deserialises MSB-first words, and presents each word on a valid/ready output with a one-word holding register. Received word layout is [15:8] address, [7:0] data.

---
 rtl/spi_slave_rx.sv | 198 +++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI slave receiver, MSB-first, oversampled on clk, valid/ready word output
// Optional full-duplex MISO path: define SPI_SLAVE_MISO_EN.
module spi_slave_rx #(
    parameter int DATA_LENGTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   SPI_CLK,
    input  logic                   SPI_SS,
    input  logic                   MOSI,
    output logic                   MISO,
    input  logic [DATA_LENGTH-1:0] tx_data,
    output logic [DATA_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   overflow,
    output logic                   frame_err
);

    localparam int CNT_W = $clog2(DATA_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_LENGTH - 1);

    typedef enum logic [1:0] {
        S_wait_ss = 2'd0,
        S_idle    = 2'd1,
        S_shift   = 2'd2,
        S_store   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, mosi_sync_q;
    logic                   ss_hist_q, sck_hist_q;
    // Fills with ones after reset; the top bit marks that the sync chains and
    // history registers hold real samples instead of their reset values.
    logic [SYNC_STAGES:0]   prime_q;

    logic ss_s, sck_s, mosi_s, primed;
    logic sck_rise, ss_fall;

    logic [DATA_LENGTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_LENGTH-1:0] rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   overflow_q, overflow_d;
    logic                   frame_err_q, frame_err_d;

    logic start, shift_en, abort, stray, accept, drop;

    // Input synchronisers and edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ss_hist_q   <= 1'b1;
            sck_hist_q  <= 1'b0;
            prime_q     <= '0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SPI_SS};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SPI_CLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            ss_hist_q   <= ss_s;
            sck_hist_q  <= sck_s;
            prime_q     <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign primed   = prime_q[SYNC_STAGES];
    assign sck_rise = sck_s & ~sck_hist_q;
    assign ss_fall  = ~ss_s & ss_hist_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_wait_ss;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_wait_ss: if (primed && ss_s) state_d = S_idle;
            S_idle:    if (ss_fall) state_d = S_shift;
            S_shift: begin
                if (ss_s) begin
                    state_d = S_idle;
                end else if (sck_rise && (bit_cnt_q == LAST_BIT)) begin
                    state_d = S_store;
                end
            end
            S_store:   state_d = S_wait_ss;
            default:   state_d = S_wait_ss;
        endcase
    end

    // FSM output decode: per-cycle datapath strobes
    always_comb begin
        start    = (state_q == S_idle) && ss_fall;
        shift_en = (state_q == S_shift) && !ss_s && sck_rise;
        abort    = (state_q == S_shift) && ss_s;
        stray    = (state_q == S_wait_ss) && primed && sck_rise;
        accept   = (state_q == S_store) && (!rx_valid_q || rx_ready);
        drop     = (state_q == S_store) && rx_valid_q && !rx_ready;
    end

    // Datapath next-state: deserialiser, holding register and status pulses
    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overflow_d  = drop;
        frame_err_d = abort || stray;
        if (start) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (shift_en) begin
            shreg_d   = {shreg_q[DATA_LENGTH-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (accept) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

`ifdef SPI_SLAVE_MISO_EN
    logic [DATA_LENGTH-1:0] tx_shreg_q, tx_shreg_d;
    logic                   miso_q, miso_d;
    logic                   sck_fall;

    assign sck_fall = ~sck_s & sck_hist_q;

    // Transmit shifter: load at frame start, advance on SPI_CLK falling edges
    always_comb begin
        tx_shreg_d = tx_shreg_q;
        if (start) begin
            tx_shreg_d = tx_data;
        end else if ((state_q == S_shift) && sck_fall) begin
            tx_shreg_d = {tx_shreg_q[DATA_LENGTH-2:0], 1'b0};
        end
        miso_d = !ss_s && tx_shreg_q[DATA_LENGTH-1];
    end

    // Transmit registers; MISO is registered so it lands one clk after the shift
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shreg_q <= '0;
            miso_q     <= 1'b0;
        end else begin
            tx_shreg_q <= tx_shreg_d;
            miso_q     <= miso_d;
        end
    end

    assign MISO = miso_q;
`else
    logic unused_tx;
    assign unused_tx = ^tx_data;
    assign MISO      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - self-checking bench for spi_slave_rx
module tb_spi_slave_rx;

    localparam int DL   = 16;
    localparam int SYNC = 2;
    localparam int HALF = 41;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          SPI_CLK  = 1'b0;
    logic          SPI_SS   = 1'b1;
    logic          MOSI     = 1'b0;
    logic          rx_ready = 1'b1;
    logic [DL-1:0] tx_data  = 16'hC3C3;
    logic          MISO;
    logic [DL-1:0] rx_data;
    logic          rx_valid;
    logic          overflow;
    logic          frame_err;

    spi_slave_rx #(.DATA_LENGTH(DL), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .SPI_CLK  (SPI_CLK),
        .SPI_SS   (SPI_SS),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard and event monitor, sampled on the falling clk edge
    logic [DL-1:0] sb_q[$];
    int   ferr_cnt       = 0;
    int   ovf_cnt        = 0;
    int   word_cnt       = 0;
    int   valid_cycles   = 0;
    int   valid_rise_cyc = -1;
    logic valid_prev     = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err === 1'b1) ferr_cnt++;
            if (overflow === 1'b1) ovf_cnt++;
            if (rx_valid === 1'b1) valid_cycles++;
            if (rx_valid === 1'b1 && valid_prev !== 1'b1) valid_rise_cyc = cyc;
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
                word_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_word actual=%h required=none", rx_data);
                end else begin
                    check("sb_word", rx_data, sb_q.pop_front());
                end
            end
        end
        valid_prev = rx_valid;
    end

    // SPI master model
    logic [DL-1:0] miso_word;
    int            last_rise_cyc;
    int            word_rise_cyc;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b);
        MOSI = b;
        wait_cyc(HALF);
        miso_word = {miso_word[DL-2:0], MISO};
        SPI_CLK = 1'b1;
        last_rise_cyc = cyc;
        wait_cyc(HALF);
        SPI_CLK = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n);
        SPI_SS = 1'b0;
        miso_word = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(bits[i]);
            if (n - i == DL) word_rise_cyc = last_rise_cyc;
        end
        wait_cyc(HALF);
        SPI_SS = 1'b1;
        wait_cyc(12);
    endtask

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        logic [15:0] exp_word;
        int          exp_words;
        int          exp_ferr;
    } vec_t;

    vec_t vecs[7];
    logic [DL-1:0] exp_miso;
    int f0, w0, v0, o0;

    initial begin
        vecs[0] = '{32'h0000A55A, 16, 16'hA55A, 1, 0};
        vecs[1] = '{32'h00000155,  9, 16'h0000, 0, 1};
        vecs[2] = '{32'h000000FF, 16, 16'h00FF, 1, 0};
        vecs[3] = '{32'h00001E1F, 17, 16'h0F0F, 1, 1};
        vecs[4] = '{32'h0000FFFF, 16, 16'hFFFF, 1, 0};
        vecs[5] = '{32'h00000000, 16, 16'h0000, 1, 0};
        vecs[6] = '{32'h00005A5A, 16, 16'h5A5A, 1, 0};
`ifdef SPI_SLAVE_MISO_EN
        exp_miso = 16'hC3C3;
`else
        exp_miso = 16'h0000;
`endif

        wait_cyc(3);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_overflow", overflow, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_miso", MISO, 0);
        rst = 1'b0;
        wait_cyc(5);

        for (int v = 0; v < 7; v++) begin
            f0 = ferr_cnt; w0 = word_cnt; v0 = valid_cycles; o0 = ovf_cnt;
            valid_rise_cyc = -1;
            if (vecs[v].exp_words == 1) sb_q.push_back(vecs[v].exp_word);
            send_frame(vecs[v].bits, vecs[v].nbits);
            check($sformatf("vec%0d_frame_err", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_words", v), word_cnt - w0, vecs[v].exp_words);
            check($sformatf("vec%0d_valid_cycles", v), valid_cycles - v0, vecs[v].exp_words);
            check($sformatf("vec%0d_overflow", v), ovf_cnt - o0, 0);
            if (vecs[v].exp_words == 1)
                check($sformatf("vec%0d_latency", v), valid_rise_cyc, word_rise_cyc + SYNC + 2);
            if (vecs[v].nbits == DL)
                check($sformatf("vec%0d_miso", v), miso_word, exp_miso);
        end

        // Holding register full: second word is dropped with one overflow pulse
        rx_ready = 1'b0;
        o0 = ovf_cnt; w0 = word_cnt;
        sb_q.push_back(16'h1234);
        send_frame(32'h1234, DL);
        send_frame(32'hBEEF, DL);
        check("hold_overflow", ovf_cnt - o0, 1);
        check("hold_rx_valid", rx_valid, 1);
        check("hold_rx_data", rx_data, 16'h1234);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        wait_cyc(1);
        check("hold_valid_fall", rx_valid, 0);
        check("hold_words", word_cnt - w0, 1);
        rx_ready = 1'b1;

        // Reset in the middle of a frame; the tail of that frame must not deliver
        w0 = word_cnt; v0 = valid_cycles;
        SPI_SS = 1'b0;
        for (int i = 7; i >= 0; i--) spi_bit(i[0]);
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(2);
        check("midrst_rx_data", rx_data, 0);
        check("midrst_rx_valid", rx_valid, 0);
        rst = 1'b0;
        for (int i = 7; i >= 0; i--) spi_bit(i[1]);
        wait_cyc(HALF);
        SPI_SS = 1'b1;
        wait_cyc(12);
        check("midrst_no_word", word_cnt - w0, 0);
        check("midrst_no_valid", valid_cycles - v0, 0);
        sb_q.push_back(16'h8001);
        send_frame(32'h8001, DL);
        check("midrst_next_word", word_cnt - w0, 1);

        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
